// File: rtl/wrr_lock_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin lock arbiter.
package wrr_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Widest one-hot vector onehot_to_idx accepts; callers zero-extend.
   localparam int MAX_N = 32;

   function automatic int unsigned onehot_to_idx(input logic [MAX_N-1:0] oh);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < MAX_N; i++) begin
         if (oh[i]) idx = idx | unsigned'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/wrr_lock_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface wrr_lock_arbiter_if #(
   parameter int N  = 4,
   parameter int WW = 4
) ();
   localparam int IDW = $clog2(N);

   logic [N-1:0]    req;
   logic [N-1:0]    last;
   logic [N*WW-1:0] weight;
   logic            ready;
   logic [N-1:0]    grant;
   logic            grant_valid;
   logic [IDW-1:0]  grant_id;

   modport master (
      output req, last, weight, ready,
      input  grant, grant_valid, grant_id
   );

   modport slave (
      input  req, last, weight, ready,
      output grant, grant_valid, grant_id
   );
endinterface

// File: rtl/wrr_lock_arbiter_rr_pick.sv
// Combinational rotating-priority picker: lowest requesting index at or above
// ptr wins, wrapping modulo N.
module rr_pick
   import wrr_arb_pkg::*;
#(
   parameter  int N   = 4,
   localparam int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   win_onehot,
   output logic [IDW-1:0] win_idx,
   output logic           any
);

   logic [2*N-1:0] dbl_req;
   logic [2*N-1:0] masked;
   logic [2*N-1:0] dbl_oh;

   // The upper copy of req covers the wrap, so a plain low-to-high priority
   // search over the masked double vector is a rotating search.
   always_comb begin
      logic found;
      // NOTE: every output of a combinational block gets a default first so
      // no path leaves it unassigned, which would infer a latch.
      found   = 1'b0;
      dbl_oh  = '0;
      dbl_req = {req, req};
      masked  = dbl_req & ({(2*N){1'b1}} << ptr);
      for (int i = 0; i < 2*N; i++) begin
         if (masked[i] && !found) begin
            found     = 1'b1;
            dbl_oh[i] = 1'b1;
         end
      end
   end

   assign win_onehot = dbl_oh[N-1:0] | dbl_oh[2*N-1:N];
   assign win_idx    = IDW'(onehot_to_idx(MAX_N'(win_onehot)));
   assign any        = |req;

endmodule

// File: rtl/wrr_lock_arbiter.sv
// Weighted round-robin arbiter that locks the grant across multi-beat packets
// and lets each owner send up to its weight in packets per turn.
module wrr_lock_arbiter
   import wrr_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int WW = 4
) (
   input logic               clk,
   input logic               rst_n,
   wrr_lock_arbiter_if.slave bus
);

   localparam int IDW = $clog2(N);

   state_t         state;
   logic [IDW-1:0] ptr;
   logic [WW-1:0]  credit;

   logic [IDW-1:0] owner_next;
   logic [IDW-1:0] pick_ptr;
   logic [N-1:0]   win_onehot;
   logic [IDW-1:0] win_idx;
   logic           win_any;
   logic [WW-1:0]  win_weight;
   logic [WW-1:0]  win_credit;
   logic           owner_req;
   logic           pkt_end;
   logic [WW-1:0]  credit_dec;
   logic           rel;

   assign owner_next = (bus.grant_id == IDW'(N-1)) ? '0 : bus.grant_id + 1'b1;

   // Searching from owner+1 puts the owner last in the rotation, so it only
   // wins a release-edge pick when it is the sole requester.
   assign pick_ptr = (state == BUSY) ? owner_next : ptr;

   rr_pick #(.N(N)) u_pick (
      .req        (bus.req),
      .ptr        (pick_ptr),
      .win_onehot (win_onehot),
      .win_idx    (win_idx),
      .any        (win_any)
   );

   assign win_weight = bus.weight[win_idx*WW +: WW];
   assign win_credit = (win_weight == '0) ? WW'(1) : win_weight;

   assign owner_req  = bus.req[bus.grant_id];
   assign pkt_end    = bus.grant_valid & bus.ready & owner_req & bus.last[bus.grant_id];
   assign credit_dec = credit - 1'b1;
   assign rel        = (state == BUSY) & (~owner_req | (pkt_end & (credit_dec == '0)));

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         ptr             <= '0;
         credit          <= '0;
         bus.grant       <= '0;
         bus.grant_valid <= 1'b0;
         bus.grant_id    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_any) begin
                  state           <= BUSY;
                  bus.grant       <= win_onehot;
                  bus.grant_valid <= 1'b1;
                  bus.grant_id    <= win_idx;
                  credit          <= win_credit;
               end
            end
            BUSY: begin
               if (rel) begin
                  ptr <= owner_next;
                  if (win_any) begin
                     bus.grant    <= win_onehot;
                     bus.grant_id <= win_idx;
                     credit       <= win_credit;
                  end else begin
                     state           <= IDLE;
                     bus.grant       <= '0;
                     bus.grant_valid <= 1'b0;
                  end
               end else if (pkt_end) begin
                  credit <= credit_dec;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wrr_lock_arbiter.sv
// Directed bench for wrr_lock_arbiter: a per-cycle behavioural model checked on
// every falling edge, plus literal grant expectations per scenario.
module tb_wrr_lock_arbiter;

   localparam int N  = 4;
   localparam int WW = 4;

   logic clk;
   logic rst_n;
   logic chk_on;
   int   n_vec;
   int   n_bad;

   wrr_lock_arbiter_if #(.N(N), .WW(WW)) bus ();

   wrr_lock_arbiter #(.N(N), .WW(WW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Model state: owner index (-1 when nobody holds the port), the last
   // reported id, the rotation start and the packets left in this turn.
   int m_owner;
   int m_id;
   int m_ptr;
   int m_credit;

   function automatic int pick(input logic [3:0] r, input int start);
      for (int k = 0; k < N; k++) begin
         if (r[(start + k) % N]) return (start + k) % N;
      end
      return -1;
   endfunction

   function automatic int wt(input int idx);
      int w;
      w = int'(bus.weight[idx*WW +: WW]);
      return (w == 0) ? 1 : w;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int         w;
      int         rp;
      logic [3:0] cand;
      if (!rst_n) begin
         m_owner  <= -1;
         m_id     <= 0;
         m_ptr    <= 0;
         m_credit <= 0;
      end else if (m_owner < 0) begin
         w = pick(bus.req, m_ptr);
         if (w >= 0) begin
            m_owner  <= w;
            m_id     <= w;
            m_credit <= wt(w);
         end
      end else if (!bus.req[m_owner] || (bus.ready && bus.last[m_owner] && m_credit == 1)) begin
         rp   = (m_owner + 1) % N;
         cand = bus.req & ~(4'b0001 << m_owner);
         if (cand == 4'b0000) cand = bus.req;
         w = pick(cand, rp);
         m_ptr <= rp;
         if (w >= 0) begin
            m_owner  <= w;
            m_id     <= w;
            m_credit <= wt(w);
         end else begin
            m_owner <= -1;
         end
      end else if (bus.ready && bus.last[m_owner]) begin
         m_credit <= m_credit - 1;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("model_grant", 32'(bus.grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
         check("model_grant_valid", 32'(bus.grant_valid), (m_owner < 0) ? 32'd0 : 32'd1);
         check("model_grant_id", 32'(bus.grant_id), 32'(m_id));
      end
   end

   // Called right after a falling edge; applies one cycle of inputs and checks
   // the grant seen after the following rising edge (exp < 0 skips the check).
   task automatic cycle(input logic [3:0] r, input logic [3:0] l, input logic rd,
                        input int exp, input string name);
      bus.req   = r;
      bus.last  = l;
      bus.ready = rd;
      @(negedge clk);
      if (exp >= 0) check(name, 32'(bus.grant), 32'(exp));
   endtask

   task automatic do_reset(input logic [15:0] w);
      bus.req    = '0;
      bus.last   = '0;
      bus.ready  = 1'b0;
      bus.weight = w;
      #1 rst_n = 1'b0;
      chk_on = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("reset_grant", 32'(bus.grant), 32'd0);
         check("reset_grant_valid", 32'(bus.grant_valid), 32'd0);
         check("reset_grant_id", 32'(bus.grant_id), 32'd0);
      end
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n      = 1'b1;
      chk_on     = 1'b0;
      n_vec      = 0;
      n_bad      = 0;
      bus.req    = '0;
      bus.last   = '0;
      bus.ready  = 1'b0;
      bus.weight = 16'h1111;
      @(negedge clk);

      // Reset/idle, then a lone request; ready low shows it is ignored in IDLE.
      do_reset(16'h1111);
      cycle(4'b0100, 4'b0000, 1'b0, 4'b0100, "idle_first_grant");
      cycle(4'b0000, 4'b0000, 1'b0, 4'b0000, "idle_after_drop");
      check("idle_id_held", 32'(bus.grant_id), 32'd2);

      // Round-robin fairness with single-beat packets.
      do_reset(16'h1111);
      for (int i = 0; i < 8; i++)
         cycle(4'b1111, 4'b1111, 1'b1, 1 << (i % 4), "rr_sequence");

      // Weight 3 on requester 0: owners 0,0,0,1,0,0,0,1.
      do_reset(16'h1113);
      for (int i = 0; i < 8; i++)
         cycle(4'b0011, 4'b0011, 1'b1, ((i % 4) == 3) ? 4'b0010 : 4'b0001, "weighted_sequence");

      // Four-beat packet under toggling ready; last is also high on an idle
      // ready-low cycle, which must not end the packet.
      do_reset(16'h1111);
      cycle(4'b0101, 4'b0000, 1'b1, 4'b0001, "bp_first_grant");
      cycle(4'b0101, 4'b0000, 1'b1, 4'b0001, "bp_beat1");
      cycle(4'b0101, 4'b0000, 1'b0, 4'b0001, "bp_stall1");
      cycle(4'b0101, 4'b0000, 1'b1, 4'b0001, "bp_beat2");
      cycle(4'b0101, 4'b0000, 1'b0, 4'b0001, "bp_stall2");
      cycle(4'b0101, 4'b0000, 1'b1, 4'b0001, "bp_beat3");
      cycle(4'b0101, 4'b0001, 1'b0, 4'b0001, "bp_last_no_beat");
      cycle(4'b0101, 4'b0001, 1'b1, 4'b0100, "bp_handoff");

      // Owner 3 abandons mid-packet; pointer wraps to 0.
      do_reset(16'h1111);
      cycle(4'b1000, 4'b0000, 1'b1, 4'b1000, "abandon_grant3");
      cycle(4'b1001, 4'b0000, 1'b1, 4'b1000, "abandon_locked");
      cycle(4'b0001, 4'b0000, 1'b1, 4'b0001, "abandon_handoff");
      check("abandon_ptr_wrap", 32'(dut.ptr), 32'd0);

      // Sole requester re-granted every turn without a bubble.
      do_reset(16'h1111);
      for (int i = 0; i < 6; i++)
         cycle(4'b0100, 4'b0100, 1'b1, 4'b0100, "sole_regrant");

      // Asynchronous reset between edges while BUSY.
      do_reset(16'h1111);
      cycle(4'b0101, 4'b0000, 1'b1, 4'b0001, "areset_busy");
      cycle(4'b0101, 4'b0000, 1'b1, 4'b0001, "areset_mid_packet");
      #2 rst_n = 1'b0;
      #1;
      check("areset_grant", 32'(bus.grant), 32'd0);
      check("areset_grant_valid", 32'(bus.grant_valid), 32'd0);
      check("areset_grant_id", 32'(bus.grant_id), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cycle(4'b0101, 4'b0000, 1'b1, 4'b0001, "areset_first_grant");
      cycle(4'b0101, 4'b0001, 1'b1, 4'b0100, "areset_handoff");

      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
